// File: rtl/snn_pkg.sv
// Shared types and helpers for the reward-modulated STDP weight updater.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int SNN_RW_W    = 8;
  localparam int SNN_TRACE_W = 8;
  localparam int PROD_W      = SNN_RW_W + SNN_TRACE_W;

  // Wide enough for any sign-extended update sum; callers keep the low bits.
  localparam int SAT_W = 32;

  // Clamp a signed sum into the unsigned range [0, 2^dw-1].
  function automatic logic [SAT_W-1:0] sat_unsigned(input logic signed [SAT_W-1:0] sum,
                                                    input int dw);
    logic signed [SAT_W-1:0] max_v;
    max_v = (SAT_W'(1) << dw) - SAT_W'(1);
    if (sum < 0)
      sat_unsigned = '0;
    else if (sum > max_v)
      sat_unsigned = max_v;
    else
      sat_unsigned = sum;
  endfunction

endpackage

// File: rtl/rstdp_update_alu.sv
// Combinational weight update: wnew = sat(w + ((reward * trace) >>> SHIFT)).
module rstdp_update_alu
  import snn_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TRACE_W = SNN_TRACE_W,
  parameter int RW_W    = SNN_RW_W,
  parameter int SHIFT   = 2
) (
  input  logic [DW-1:0]      i_w,
  input  logic [RW_W-1:0]    i_reward,
  input  logic [TRACE_W-1:0] i_trace,
  output logic [DW-1:0]      o_wnew
);

  localparam int P_W   = RW_W + TRACE_W;
  localparam int SUM_W = P_W + 1;

  logic signed [P_W-1:0]   w_reward_x;
  logic signed [P_W-1:0]   w_trace_x;
  logic signed [P_W-1:0]   w_prod;
  logic signed [P_W-1:0]   w_delta;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SAT_W-1:0] w_sum_x;
  logic [SAT_W-1:0]        w_sat;
  logic                    w_unused_sat;

  // Operands are widened first so the product is exact in P_W bits.
  assign w_reward_x = {{TRACE_W{i_reward[RW_W-1]}}, i_reward};
  assign w_trace_x  = {{RW_W{i_trace[TRACE_W-1]}}, i_trace};
  assign w_prod     = w_reward_x * w_trace_x;
  assign w_delta    = w_prod >>> SHIFT;
  assign w_sum      = $signed({{(SUM_W-DW){1'b0}}, i_w}) + $signed({w_delta[P_W-1], w_delta});
  assign w_sum_x    = {{(SAT_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
  assign w_sat      = sat_unsigned(w_sum_x, DW);
  assign o_wnew     = w_sat[DW-1:0];
  assign w_unused_sat = ^w_sat[SAT_W-1:DW];

endmodule

// File: rtl/reward_weight_updater.sv
// Sweeps every synapse on a reward event: read weight, apply R-STDP update, write back.
module reward_weight_updater
  import snn_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DW      = 8,
  parameter int TRACE_W = 8,
  parameter int RW_W    = 8,
  parameter int SHIFT   = 2,
  parameter int N_SYN   = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [RW_W-1:0]    reward,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  trace_addr,
  input  logic [TRACE_W-1:0] trace_data,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output state_t             o_state
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [RW_W-1:0]   r_reward;
  logic [DW-1:0]     r_wnew;
  logic [DW-1:0]     w_wnew;
  logic              w_last;

  assign w_last = (r_idx == ADDR_W'(N_SYN - 1));

  rstdp_update_alu #(
    .DW      (DW),
    .TRACE_W (TRACE_W),
    .RW_W    (RW_W),
    .SHIFT   (SHIFT)
  ) u_alu (
    .i_w      (mem_rdata),
    .i_reward (r_reward),
    .i_trace  (trace_data),
    .o_wnew   (w_wnew)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = READ;
      READ:    w_state_nxt = CALC;
      CALC:    w_state_nxt = WRITE;
      WRITE:   w_state_nxt = w_last ? DONE : READ;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != IDLE);
    done   = (r_state == DONE);
    mem_we = (r_state == WRITE);
  end

  // idx returns to 0 after DONE so the shared address reads 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_reward <= '0;
      r_wnew   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_reward <= reward;
          r_idx    <= '0;
        end
        CALC:  r_wnew <= w_wnew;
        WRITE: if (!w_last) r_idx <= r_idx + 1'b1;
        DONE:  r_idx <= '0;
        default: ;
      endcase
    end
  end

  assign mem_addr   = r_idx;
  assign trace_addr = r_idx;
  assign mem_wdata  = r_wnew;
  assign o_state    = r_state;

endmodule

// File: tb/tb_reward_weight_updater.sv
// Directed bench for reward_weight_updater with a 1-cycle-read memory and a trace table.
module tb_reward_weight_updater;
  import snn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  reward = '0;
  logic        busy, done, mem_we;
  logic [3:0]  trace_addr, mem_addr;
  logic [7:0]  trace_data, mem_wdata, mem_rdata;
  state_t      st;

  logic [7:0]  mem [16];
  logic [7:0]  trace_tab [16];
  logic [7:0]  exp_mem [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_addr = '0;
  logic [7:0]  tb_wdata = '0;

  int checks = 0;
  int errors = 0;
  int n_we;

  reward_weight_updater dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .reward     (reward),
    .busy       (busy),
    .done       (done),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .o_state    (st)
  );

  // clock / memory model / trace unit
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
    else if (tb_we)
      mem[tb_addr] <= tb_wdata;
    mem_rdata <= mem[mem_addr];
  end

  assign trace_data = trace_tab[trace_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_load(input int a, input logic [7:0] v);
    tb_addr  = a[3:0];
    tb_wdata = v;
    tb_we    = 1'b1;
    step();
    tb_we    = 1'b0;
    exp_mem[a] = v;
  endtask

  task automatic clear_traces();
    for (int i = 0; i < 16; i++) trace_tab[i] = 8'sd0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  task automatic sweep(input logic [7:0] rw);
    int n;
    reward = rw;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk("sweep_done_seen", 32'(done), 32'd1);
    step();
  endtask

  initial begin
    clear_traces();
    // reset state
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_state", 32'(st), 32'(IDLE));
    step();
    rst_n = 1'b1;
    step();

    // sweep 1: mem[3]=100, trace[3]=+10, reward=+4 -> 110; plus timing
    for (int i = 0; i < 16; i++) mem_load(i, 8'(i * 7 + 1));
    mem_load(3, 8'd100);
    trace_tab[3] = 8'sd10;
    reward = 8'sd4;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n_we   = 0;
    for (int c = 1; c <= 50; c++) begin
      chk($sformatf("t_busy_c%0d", c), 32'(busy), 32'(c <= 49));
      chk($sformatf("t_done_c%0d", c), 32'(done), 32'(c == 49));
      chk($sformatf("t_we_c%0d", c), 32'(mem_we), 32'((c % 3 == 0) && (c <= 48)));
      if (mem_we) begin
        chk($sformatf("t_waddr_c%0d", c), 32'(mem_addr), 32'(n_we));
        n_we++;
      end
      if (c == 10) begin
        start  = 1'b1;
        reward = 8'h80;
      end else begin
        start  = 1'b0;
      end
      step();
    end
    chk("t_we_count", 32'(n_we), 32'd16);
    exp_mem[3] = 8'd110;
    check_mem("s1");

    // sweep 2: floor saturation 5 + (-160>>>2) -> 0
    clear_traces();
    mem_load(0, 8'd5);
    trace_tab[0] = 8'sd20;
    sweep(8'hF8);
    exp_mem[0] = 8'd0;
    check_mem("s2");

    // sweep 3: ceiling saturation 250 + 4032 -> 255
    clear_traces();
    mem_load(1, 8'd250);
    trace_tab[1] = 8'sd127;
    sweep(8'sd127);
    exp_mem[1] = 8'd255;
    check_mem("s3");

    // sweep 4: rounding toward -inf: -1>>>2 = -1; (+1)>>>2 = 0
    clear_traces();
    mem_load(2, 8'd50);
    mem_load(5, 8'd30);
    trace_tab[2] = 8'sd1;
    trace_tab[5] = 8'hFF;
    sweep(8'hFF);
    exp_mem[2] = 8'd49;
    exp_mem[5] = 8'd30;
    check_mem("s4");

    // sweep 5: reward toggles every cycle; only the latched +4 counts
    clear_traces();
    mem_load(3, 8'd100);
    mem_load(7, 8'd100);
    trace_tab[3] = 8'sd10;
    trace_tab[7] = 8'hF6;
    reward = 8'sd4;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      reward = (n % 2 == 0) ? 8'h9C : 8'sd4;
      step();
    end
    chk("tog_done_seen", 32'(done), 32'd1);
    step();
    exp_mem[3] = 8'd110;
    exp_mem[7] = 8'd90;
    check_mem("s5");

    // reset mid-sweep at cycle 20 (idx 6 in CALC)
    for (int i = 0; i < 16; i++) begin
      mem_load(i, 8'(i));
      trace_tab[i] = 8'sd4;
    end
    reward = 8'sd4;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int c = 1; c < 20; c++) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_idx_before", 32'(mem_addr), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_taddr", 32'(trace_addr), 0);
    chk("mid_rst_wdata", 32'(mem_wdata), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) exp_mem[i] = 8'(i + 4);
    check_mem("rst");
    sweep(8'sd4);
    for (int i = 0; i < 16; i++) exp_mem[i] = exp_mem[i] + 8'd4;
    check_mem("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reward_weight_updater.md
Name: reward_weight_updater

Overview:
- Reward-modulated STDP write-back engine directly upstream of the synaptic weight Memory block; it is the block that drives that Memory's we/addr/wdata ports and consumes its rdata.
- On a reward event it sweeps every synapse address in order. For each address it does a read, then applies w_new = sat(w + ((reward * trace) >>> SHIFT)), then writes w_new back.
- Eligibility traces come from the trace unit over a registered-address lookup.

Parameters:
- ADDR_W, 4, weight memory address width; must match Memory.
- DW, 8, weight width (unsigned); must match Memory.
- TRACE_W, 8, eligibility trace width (signed two's complement).
- RW_W, 8, reward width (signed two's complement).
- SHIFT, 2, learning-rate right shift (arithmetic), 0..RW_W+TRACE_W-1.
- N_SYN, 1<<ADDR_W, number of addresses swept (0..N_SYN-1); 1 <= N_SYN <= 2^ADDR_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- reward  in  RW_W  signed reward; latched when start is accepted.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at sweep completion.
- trace_addr  out  ADDR_W  synapse index for the trace lookup.
- trace_data  in  TRACE_W  signed trace for trace_addr; combinational from the trace unit, valid in the same cycle.
- mem_we  out  1  Memory write enable.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DW  Memory write data.
- mem_rdata  in  DW  Memory read data; one-cycle registered read latency.

Behaviour:
- Reset (async, any state, including mid-sweep):
  - Outputs: busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, trace_addr=0.
  - Internal: idx=0, reward_q=0, state=IDLE.
  - Writes already completed remain in Memory; no rollback.
- Output timing: every output is a register or a direct decode of state/idx. There is no combinational input-to-output path.
- Address sharing: mem_addr = trace_addr = idx in all non-IDLE states.
- IDLE:
  - If start=1: latch reward into reward_q, set idx=0, go to READ.
  - Otherwise stay in IDLE.
- READ: mem_we=0, mem_addr=idx; go to CALC. Memory returns mem[idx] on mem_rdata during CALC.
- CALC:
  - mem_we=0.
  - Compute the update and register it into wnew_q, then go to WRITE.
  - prod = reward_q * trace_data, signed, RW_W+TRACE_W bits, exact.
  - delta = prod >>> SHIFT (arithmetic shift; rounds toward -inf).
  - sum = zero-extended mem_rdata + sign-extended delta, computed in RW_W+TRACE_W+1 bits so there is no overflow.
  - wnew = 0 if sum < 0; 2^DW-1 if sum > 2^DW-1; otherwise sum[DW-1:0].
- WRITE:
  - mem_we=1, mem_addr=idx, mem_wdata=wnew_q.
  - If idx == N_SYN-1: go to DONE. Otherwise idx += 1 and go to READ.
- DONE: done=1 for exactly this cycle, busy=1, mem_we=0; go to IDLE.
- Sweep timing: 3 cycles per synapse. If start is sampled at edge 0, the sweep occupies cycles 1..3*N_SYN and done is high in cycle 3*N_SYN+1.
- start while busy: ignored, with no queueing. A start in the DONE cycle is also ignored.
- reward changes mid-sweep: no effect; only reward_q is used.
- Zero reward or zero trace: the full sweep still runs and each weight is rewritten with its unchanged value.
- idx never exceeds N_SYN-1, so there is no wrap-around.
- mem_we is high only in WRITE. The Memory read-during-write returns the old data, which is unused.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum typedef: IDLE, READ, CALC, WRITE, DONE;
  - localparam PROD_W = RW_W+TRACE_W;
  - a sat_unsigned function.
- Sub-module rstdp_update_alu: purely combinational multiply/shift/add/saturate. Inputs w, reward, trace; output wnew. It is unit-testable on its own.
- The FSM, index counter and registers stay in reward_weight_updater.

Test Plan (DW=8, TRACE_W=8, RW_W=8, SHIFT=2, N_SYN=16, bench Memory model with 1-cycle read):
- mem[3]=100, trace[3]=+10, reward=+4 -> 40>>>2=10 -> mem[3]=110; all entries with trace 0 are unchanged.
- mem[0]=5, trace[0]=+20, reward=-8 -> delta=-40 -> mem[0]=0 (floor saturation). Also: mem[1]=250, trace[1]=127, reward=127 -> delta=4032 -> mem[1]=255.
- mem[2]=50, trace[2]=+1, reward=-1 -> -1>>>2=-1 -> mem[2]=49 (rounding toward -inf).
- Timing: start pulse at cycle 0 -> busy high cycles 1..49; done high only in cycle 49. Exactly 16 mem_we pulses, at addresses 0..15 in order, one every 3 cycles. A second start at cycle 10 is ignored.
- Reset: assert rst_n=0 at cycle 20 (mid-sweep, idx=6) -> outputs are 0 immediately; entries 0..5 are updated and 6..15 are unchanged. After release, the next start performs a full sweep from 0.
- reward toggled every cycle during a sweep -> all updates use the value latched at start.
